// File: rtl/mult_dispatch.sv
// mult_dispatch: queues 8x8 operand pairs and runs them one at a time through an
// external multiplier, with a hang timeout and a held downstream result.
module mult_dispatch #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [7:0]                    in_a,
  input  logic [7:0]                    in_b,
  output logic                          in_ready,
  output logic                          mul_start,
  output logic [7:0]                    mul_a,
  output logic [7:0]                    mul_b,
  input  logic                          mul_done,
  input  logic [15:0]                   mul_product,
  output logic                          out_valid,
  output logic [15:0]                   out_product,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_timeout,
  input  logic                          err_clr
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t state, state_nx;
  logic [15:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [TW-1:0] timer;
  logic push, pop, expire;
  assign in_ready = rst && (fifo_count < CW'(FIFO_DEPTH));
  assign push = in_valid && in_ready;
  assign pop = (state == IDLE) && (fifo_count != '0);
  assign mul_start = (state == ISSUE);
  // timeout fires on the last permitted WAIT cycle; a done in that cycle still wins
  assign expire = (state == WAIT) && !mul_done && (timer == TW'(TIMEOUT - 1));
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = pop ? ISSUE : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = mul_done ? HOLD : expire ? IDLE : WAIT;
      HOLD:    state_nx = out_ready ? IDLE : HOLD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {in_a, in_b};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      fifo_count <= '0;
      mul_a <= '0;
      mul_b <= '0;
      out_valid <= 1'b0;
      out_product <= '0;
      err_timeout <= 1'b0;
      timer <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr <= rptr + 1'b1;
        {mul_a, mul_b} <= mem[rptr];
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      timer <= (state == WAIT) ? timer + 1'b1 : '0;
      if (state == WAIT && mul_done) out_product <= mul_product;
      out_valid <= (state == WAIT) ? mul_done : (state == HOLD) ? !out_ready : 1'b0;
      err_timeout <= expire ? 1'b1 : err_clr ? 1'b0 : err_timeout;
    end
endmodule
